// File: rtl/rle_codec_p_pkg.sv
// rtl/rle_codec_p_pkg.sv - shared state encodings, mode and pair-layout constants for the RLE codec
package rle_pkg;

    typedef logic [2:0] rle_state_t;

    localparam rle_state_t ST_IDLE    = 3'd0;
    localparam rle_state_t ST_RD_REQ  = 3'd1;
    localparam rle_state_t ST_RD_WAIT = 3'd2;
    localparam rle_state_t ST_PROC    = 3'd3;
    localparam rle_state_t ST_WR      = 3'd4;
    localparam rle_state_t ST_FLUSH   = 3'd5;
    localparam rle_state_t ST_DONE    = 3'd6;
    localparam rle_state_t ST_ERR     = 3'd7;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int PAIR_SYM_OFS = 0;
    localparam int PAIR_CNT_OFS = 1;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rle_codec_p_if.sv
// rtl/rle_codec_p_if.sv - memory port A bundle and codec-to-packer byte channel
interface rle_mem_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              port_clk;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              we;

    modport master (output port_clk, addr, data_in, we, input data_out);
    modport slave  (input port_clk, addr, data_in, we, output data_out);
endinterface

interface rle_pack_if #(
    parameter int DATA_W = 32
);
    logic [7:0]        byte_in;
    logic              valid;
    logic              flush;
    logic [DATA_W-1:0] word;
    logic              word_valid;
    logic [3:0]        byte_cnt;

    modport master (output byte_in, valid, flush, input word, word_valid, byte_cnt);
    modport slave  (input byte_in, valid, flush, output word, word_valid, byte_cnt);
endinterface

// File: rtl/rle_codec_p_packer.sv
// rtl/rle_codec_p_packer.sv - gathers output bytes little-endian into one memory word
module rle_word_packer
    import rle_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic       clk,
    input logic       nreset,
    rle_pack_if.slave pk
);

    localparam int         BYTES   = bytes_per_word(DATA_W);
    localparam logic [3:0] BYTES_C = 4'(BYTES);

    logic [DATA_W-1:0] word_q, word_d;
    logic [3:0]        cnt_q, cnt_d;

    // flush clears the word so a partial last word goes out zero-padded
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (pk.flush) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (pk.valid && cnt_q != BYTES_C) begin
            for (int i = 0; i < BYTES; i++) begin
                if (cnt_q == 4'(i)) word_d[8*i +: 8] = pk.byte_in;
            end
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pk.word       = word_q;
    assign pk.byte_cnt   = cnt_q;
    assign pk.word_valid = (cnt_q == BYTES_C);

endmodule

// File: rtl/rle_codec_p.sv
// rtl/rle_codec_p.sv - memory-mastering RLE encoder/decoder over (symbol, count) byte pairs
module rle_codec_p
    import rle_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MAX_RUN = 255
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic              mode,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       src_size,
    input  logic [31:0]       dst_addr,
    output logic [31:0]       dst_size,
    output logic              done,
    output logic              err,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic [DATA_W-1:0] port_A_data_in,
    input  logic [DATA_W-1:0] port_A_data_out,
    output logic              port_A_we
);

    localparam int          BYTES      = bytes_per_word(DATA_W);
    localparam logic [31:0] BYTES_W    = 32'(BYTES);
    localparam logic [31:0] ALIGN_MASK = BYTES_W - 32'd1;
    localparam logic [3:0]  LAST_POS   = 4'(BYTES - 1);
    localparam logic [7:0]  MAX_RUN_B  = 8'(MAX_RUN);

    rle_pack_if #(.DATA_W(DATA_W)) pk ();

    rle_word_packer #(.DATA_W(DATA_W)) u_packer (
        .clk    (clk),
        .nreset (nreset),
        .pk     (pk.slave)
    );

    rle_state_t        state_q, state_d;
    logic              mode_q, mode_d;
    logic [31:0]       src_left_q, src_left_d;
    logic [31:0]       rd_addr_q, rd_addr_d;
    logic [31:0]       dst_ptr_q, dst_ptr_d;
    logic [31:0]       dst_size_q, dst_size_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] in_word_q, in_word_d;
    logic [3:0]        in_pos_q, in_pos_d;
    logic              avail_q, avail_d;
    logic [7:0]        cur_sym_q, cur_sym_d;
    logic [7:0]        run_cnt_q, run_cnt_d;
    logic              pend_q, pend_d;
    logic [7:0]        pend_cnt_q, pend_cnt_d;
    logic              phase_q, phase_d;

    logic       emit;
    logic [7:0] emit_byte;
    logic [7:0] in_byte;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        src_left_d = src_left_q;
        rd_addr_d  = rd_addr_q;
        dst_ptr_d  = dst_ptr_q;
        dst_size_d = dst_size_q;
        done_d     = done_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        in_word_d  = in_word_q;
        in_pos_d   = in_pos_q;
        avail_d    = avail_q;
        cur_sym_d  = cur_sym_q;
        run_cnt_d  = run_cnt_q;
        pend_d     = pend_q;
        pend_cnt_d = pend_cnt_q;
        phase_d    = phase_q;
        emit       = 1'b0;
        emit_byte  = 8'h00;
        pk.flush   = 1'b0;

        in_byte = 8'h00;
        for (int i = 0; i < BYTES; i++) begin
            if (in_pos_q == 4'(i)) in_byte = in_word_q[8*i +: 8];
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    mode_d     = mode;
                    src_left_d = src_size;
                    rd_addr_d  = src_addr;
                    dst_ptr_d  = dst_addr;
                    dst_size_d = 32'd0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    avail_d    = 1'b0;
                    in_pos_d   = 4'd0;
                    run_cnt_d  = 8'd0;
                    pend_d     = 1'b0;
                    phase_d    = 1'b0;
                    pk.flush   = 1'b1;
                    if ((src_addr & ALIGN_MASK) != 32'd0 || (dst_addr & ALIGN_MASK) != 32'd0) begin
                        state_d = ST_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (src_size == 32'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (mode == MODE_DEC && src_size[0]) begin
                        state_d = ST_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_RD_REQ;
                        addr_d  = ADDR_W'(src_addr);
                    end
                end
            end
            // address was registered on entry; data is valid at the edge leaving RD_WAIT
            ST_RD_REQ: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                in_word_d = port_A_data_out;
                in_pos_d  = 4'd0;
                avail_d   = 1'b1;
                rd_addr_d = rd_addr_q + BYTES_W;
                state_d   = ST_PROC;
            end
            ST_PROC: begin
                if (pk.word_valid) begin
                    state_d   = ST_WR;
                    we_d      = 1'b1;
                    addr_d    = ADDR_W'(dst_ptr_q);
                    wdata_d   = pk.word;
                    dst_ptr_d = dst_ptr_q + BYTES_W;
                    pk.flush  = 1'b1;
                end else if (pend_q) begin
                    emit      = 1'b1;
                    emit_byte = pend_cnt_q;
                    pend_d    = 1'b0;
                end else if (mode_q == MODE_DEC && run_cnt_q != 8'd0) begin
                    emit      = 1'b1;
                    emit_byte = cur_sym_q;
                    run_cnt_d = run_cnt_q - 8'd1;
                end else if (src_left_q == 32'd0) begin
                    if (mode_q == MODE_ENC && run_cnt_q != 8'd0) begin
                        emit       = 1'b1;
                        emit_byte  = cur_sym_q;
                        pend_cnt_d = run_cnt_q;
                        pend_d     = 1'b1;
                        run_cnt_d  = 8'd0;
                    end else if (pk.byte_cnt != 4'd0) begin
                        state_d   = ST_FLUSH;
                        we_d      = 1'b1;
                        addr_d    = ADDR_W'(dst_ptr_q);
                        wdata_d   = pk.word;
                        dst_ptr_d = dst_ptr_q + BYTES_W;
                        pk.flush  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else if (!avail_q) begin
                    state_d = ST_RD_REQ;
                    addr_d  = ADDR_W'(rd_addr_q);
                end else begin
                    src_left_d = src_left_q - 32'd1;
                    in_pos_d   = in_pos_q + 4'd1;
                    if (in_pos_q == LAST_POS) avail_d = 1'b0;
                    if (mode_q == MODE_ENC) begin
                        if (run_cnt_q == 8'd0) begin
                            cur_sym_d = in_byte;
                            run_cnt_d = 8'd1;
                        end else if (in_byte == cur_sym_q && run_cnt_q < MAX_RUN_B) begin
                            run_cnt_d = run_cnt_q + 8'd1;
                        end else begin
                            // symbol goes out now, its count on the next cycle
                            emit       = 1'b1;
                            emit_byte  = cur_sym_q;
                            pend_cnt_d = run_cnt_q;
                            pend_d     = 1'b1;
                            cur_sym_d  = in_byte;
                            run_cnt_d  = 8'd1;
                        end
                    end else if (phase_q == 1'(PAIR_SYM_OFS)) begin
                        cur_sym_d = in_byte;
                        phase_d   = 1'(PAIR_CNT_OFS);
                    end else if (in_byte == 8'd0) begin
                        state_d = ST_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        run_cnt_d = in_byte;
                        phase_d   = 1'(PAIR_SYM_OFS);
                    end
                end
            end
            ST_WR: state_d = ST_PROC;
            ST_FLUSH: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        pk.valid   = emit;
        pk.byte_in = emit_byte;
        if (emit) dst_size_d = dst_size_q + 32'd1;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_ENC;
            src_left_q <= '0;
            rd_addr_q  <= '0;
            dst_ptr_q  <= '0;
            dst_size_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            in_word_q  <= '0;
            in_pos_q   <= '0;
            avail_q    <= 1'b0;
            cur_sym_q  <= '0;
            run_cnt_q  <= '0;
            pend_q     <= 1'b0;
            pend_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            src_left_q <= src_left_d;
            rd_addr_q  <= rd_addr_d;
            dst_ptr_q  <= dst_ptr_d;
            dst_size_q <= dst_size_d;
            done_q     <= done_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            in_word_q  <= in_word_d;
            in_pos_q   <= in_pos_d;
            avail_q    <= avail_d;
            cur_sym_q  <= cur_sym_d;
            run_cnt_q  <= run_cnt_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
            phase_q    <= phase_d;
        end
    end

    assign port_A_clk     = clk;
    assign port_A_addr    = addr_q;
    assign port_A_data_in = wdata_q;
    assign port_A_we      = we_q;
    assign dst_size       = dst_size_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_rle_codec_p.sv
// tb/tb_rle_codec_p.sv - directed bench for rle_codec_p with 32-bit/MAX_RUN=255 and 64-bit/MAX_RUN=100 instances
module tb_rle_codec_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nreset, start_a, start_b, mode, sel;
    logic [31:0] src_addr, src_size, dst_addr;
    logic [31:0] dst_size_a, dst_size_b;
    logic        done_a, done_b, err_a, err_b;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_a = 0, wr_b = 0, bad_addr = 0;
    logic [7:0]  bm [0:4095];

    rle_mem_if #(.ADDR_W(16), .DATA_W(32)) mem_a ();
    rle_mem_if #(.ADDR_W(16), .DATA_W(64)) mem_b ();

    rle_codec_p #(.ADDR_W(16), .DATA_W(32), .MAX_RUN(255)) dut_a (
        .clk(clk), .nreset(nreset), .start(start_a), .mode(mode),
        .src_addr(src_addr), .src_size(src_size), .dst_addr(dst_addr),
        .dst_size(dst_size_a), .done(done_a), .err(err_a),
        .port_A_clk(mem_a.port_clk), .port_A_addr(mem_a.addr),
        .port_A_data_in(mem_a.data_in), .port_A_data_out(mem_a.data_out),
        .port_A_we(mem_a.we)
    );

    rle_codec_p #(.ADDR_W(16), .DATA_W(64), .MAX_RUN(100)) dut_b (
        .clk(clk), .nreset(nreset), .start(start_b), .mode(mode),
        .src_addr(src_addr), .src_size(src_size), .dst_addr(dst_addr),
        .dst_size(dst_size_b), .done(done_b), .err(err_b),
        .port_A_clk(mem_b.port_clk), .port_A_addr(mem_b.addr),
        .port_A_data_in(mem_b.data_in), .port_A_data_out(mem_b.data_out),
        .port_A_we(mem_b.we)
    );

    wire        done_s     = sel ? done_b : done_a;
    wire        err_s      = sel ? err_b : err_a;
    wire [31:0] dst_size_s = sel ? dst_size_b : dst_size_a;

    // shared byte-addressed memory; read data registered one edge after the address
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) mem_a.data_out[8*i +: 8] <= bm[int'(mem_a.addr) + i];
        for (int i = 0; i < 8; i++) mem_b.data_out[8*i +: 8] <= bm[int'(mem_b.addr) + i];
        if (mem_a.we) for (int i = 0; i < 4; i++) bm[int'(mem_a.addr) + i] = mem_a.data_in[8*i +: 8];
        if (mem_b.we) for (int i = 0; i < 8; i++) bm[int'(mem_b.addr) + i] = mem_b.data_in[8*i +: 8];
    end

    always @(negedge clk) begin
        if (mem_a.we) wr_a++;
        if (mem_b.we) wr_b++;
        if (mem_a.addr[1:0] != 2'd0) bad_addr++;
        if (mem_b.addr[2:0] != 3'd0) bad_addr++;
    end

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    task automatic run_op(input logic which, input logic m, input logic [31:0] s,
                          input logic [31:0] n, input logic [31:0] d, output int cyc);
        @(negedge clk);
        sel = which; mode = m; src_addr = s; src_size = n; dst_addr = d;
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        cyc = 0;
        while (!done_s && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (done_s !== 1'b1) begin
            n_fail++;
            $display("FAIL op_timeout: done=%b after %0d cycles, required 1", done_s, cyc);
        end
    endtask

    task automatic test_reset;
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({done_a, err_a, mem_a.we, done_b, err_b, mem_b.we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 000000", {done_a, err_a, mem_a.we, done_b, err_b, mem_b.we});
        end
        n_tests++;
        if (dst_size_a !== 32'd0 || dst_size_b !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_dst_size: got %0d/%0d required 0", dst_size_a, dst_size_b);
        end
        n_tests++;
        if (mem_a.addr !== 16'd0 || mem_a.data_in !== 32'd0 || mem_b.data_in !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_port: addr=%h din=%h required 0", mem_a.addr, mem_a.data_in);
        end
        nreset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_encode_distinct(input logic which, input logic [31:0] dst);
        int cyc, e;
        for (int i = 0; i < 120; i++) bm[int'(dst) + i] = 8'hEE;
        run_op(which, 1'b0, 32'h0, 32'd39, dst, cyc);
        n_tests++;
        if (err_s !== 1'b0 || dst_size_s !== 32'd78) begin
            n_fail++;
            $display("FAIL enc39_size: err=%b dst_size=%0d required err=0 dst_size=78", err_s, dst_size_s);
        end
        e = 0;
        for (int i = 0; i < 39; i++)
            if (bm[int'(dst) + 2*i] !== pat(i) || bm[int'(dst) + 2*i + 1] !== 8'h01) e++;
        n_tests++;
        if (e != 0) begin
            n_fail++;
            $display("FAIL enc39_pairs: %0d bad pairs, required 0", e);
        end
        n_tests++;
        if (bm[int'(dst) + 78] !== 8'h00 || bm[int'(dst) + 79] !== 8'h00) begin
            n_fail++;
            $display("FAIL enc39_pad: got %h %h required 00 00", bm[int'(dst) + 78], bm[int'(dst) + 79]);
        end
    endtask

    task automatic test_encode_runs;
        int cyc;
        for (int i = 0; i < 300; i++) bm[12'h300 + i] = 8'hAA;
        for (int i = 0; i < 16; i++) begin
            bm[12'h200 + i] = 8'hEE;
            bm[12'h280 + i] = 8'hEE;
        end
        run_op(1'b0, 1'b0, 32'h300, 32'd300, 32'h200, cyc);
        n_tests++;
        if (dst_size_a !== 32'd4 || {bm[12'h203], bm[12'h202], bm[12'h201], bm[12'h200]} !== 32'h2DAAFFAA) begin
            n_fail++;
            $display("FAIL enc_run255: size=%0d word=%h%h%h%h required 4 2daaffaa", dst_size_a,
                     bm[12'h203], bm[12'h202], bm[12'h201], bm[12'h200]);
        end
        run_op(1'b1, 1'b0, 32'h300, 32'd300, 32'h280, cyc);
        n_tests++;
        if (dst_size_b !== 32'd6 || {bm[12'h287], bm[12'h286], bm[12'h285], bm[12'h284],
                                     bm[12'h283], bm[12'h282], bm[12'h281], bm[12'h280]} !== 64'h000064AA64AA64AA) begin
            n_fail++;
            $display("FAIL enc_run100: size=%0d b0=%h b1=%h b6=%h required 6 aa 64 00", dst_size_b,
                     bm[12'h280], bm[12'h281], bm[12'h286]);
        end
    endtask

    task automatic test_decode;
        int cyc, e;
        for (int i = 0; i < 320; i++) begin
            bm[12'h500 + i] = 8'hEE;
            bm[12'h700 + i] = 8'hEE;
            bm[12'h900 + i] = 8'hEE;
        end
        run_op(1'b0, 1'b1, 32'hC8, 32'd78, 32'h500, cyc);
        e = 0;
        for (int i = 0; i < 39; i++) if (bm[12'h500 + i] !== pat(i)) e++;
        n_tests++;
        if (err_a !== 1'b0 || dst_size_a !== 32'd39 || e != 0) begin
            n_fail++;
            $display("FAIL dec39_w32: err=%b size=%0d bad=%0d required 0 39 0", err_a, dst_size_a, e);
        end
        run_op(1'b0, 1'b1, 32'h200, 32'd4, 32'h700, cyc);
        e = 0;
        for (int i = 0; i < 300; i++) if (bm[12'h700 + i] !== 8'hAA) e++;
        n_tests++;
        if (dst_size_a !== 32'd300 || e != 0) begin
            n_fail++;
            $display("FAIL dec300_w32: size=%0d bad=%0d required 300 0", dst_size_a, e);
        end
        for (int i = 0; i < 48; i++) bm[12'h500 + i] = 8'hEE;
        run_op(1'b1, 1'b1, 32'hC8, 32'd78, 32'h500, cyc);
        e = 0;
        for (int i = 0; i < 39; i++) if (bm[12'h500 + i] !== pat(i)) e++;
        n_tests++;
        if (dst_size_b !== 32'd39 || e != 0 || bm[12'h500 + 39] !== 8'h00) begin
            n_fail++;
            $display("FAIL dec39_w64: size=%0d bad=%0d pad=%h required 39 0 00", dst_size_b, e, bm[12'h500 + 39]);
        end
        run_op(1'b1, 1'b1, 32'h280, 32'd6, 32'h900, cyc);
        e = 0;
        for (int i = 0; i < 300; i++) if (bm[12'h900 + i] !== 8'hAA) e++;
        for (int i = 300; i < 304; i++) if (bm[12'h900 + i] !== 8'h00) e++;
        n_tests++;
        if (dst_size_b !== 32'd300 || e != 0) begin
            n_fail++;
            $display("FAIL dec300_w64: size=%0d bad=%0d required 300 0", dst_size_b, e);
        end
    endtask

    task automatic test_decode_errors;
        int cyc, w0;
        logic [15:0] a0;
        logic [7:0] stream [0:9];
        stream = '{8'h11, 8'h03, 8'h22, 8'h03, 8'h33, 8'h02, 8'h44, 8'h00, 8'h55, 8'h01};
        for (int i = 0; i < 10; i++) bm[12'hA00 + i] = stream[i];
        run_op(1'b0, 1'b1, 32'hA00, 32'd10, 32'hB00, cyc);
        n_tests++;
        if (err_a !== 1'b1 || done_a !== 1'b1 || dst_size_a !== 32'd8) begin
            n_fail++;
            $display("FAIL dec_cnt0: err=%b done=%b size=%0d required 1 1 8", err_a, done_a, dst_size_a);
        end
        n_tests++;
        if (bm[12'hB03] !== 8'h22 || bm[12'hB07] !== 8'h33) begin
            n_fail++;
            $display("FAIL dec_cnt0_data: got %h %h required 22 33", bm[12'hB03], bm[12'hB07]);
        end
        w0 = wr_a;
        a0 = mem_a.addr;
        run_op(1'b0, 1'b1, 32'hA00, 32'd5, 32'hB00, cyc);
        repeat (3) @(negedge clk);
        n_tests++;
        if (err_a !== 1'b1 || wr_a != w0 || mem_a.addr !== a0) begin
            n_fail++;
            $display("FAIL dec_odd: err=%b writes=%0d addr=%h required 1 0 %h", err_a, wr_a - w0, mem_a.addr, a0);
        end
    endtask

    task automatic test_boundaries;
        int cyc, w0;
        w0 = wr_a;
        run_op(1'b0, 1'b0, 32'h0, 32'd0, 32'hC8, cyc);
        repeat (3) @(negedge clk);
        n_tests++;
        if (cyc > 3 || err_a !== 1'b0 || dst_size_a !== 32'd0 || wr_a != w0) begin
            n_fail++;
            $display("FAIL size0: cyc=%0d err=%b size=%0d writes=%0d required <=3 0 0 0", cyc, err_a, dst_size_a, wr_a - w0);
        end
        w0 = wr_a;
        run_op(1'b0, 1'b0, 32'h0, 32'd39, 32'hC9, cyc);
        n_tests++;
        if (err_a !== 1'b1 || wr_a != w0) begin
            n_fail++;
            $display("FAIL misaligned_dst: err=%b writes=%0d required 1 0", err_a, wr_a - w0);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        @(negedge clk);
        sel = 1'b0; mode = 1'b0; src_addr = 32'h0; src_size = 32'd39; dst_addr = 32'hC8;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (40) @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        n_tests++;
        if ({done_a, err_a, mem_a.we} !== 3'b000 || dst_size_a !== 32'd0 || mem_a.addr !== 16'd0 || mem_a.data_in !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: done=%b err=%b we=%b size=%0d addr=%h required all 0",
                     done_a, err_a, mem_a.we, dst_size_a, mem_a.addr);
        end
        @(negedge clk);
        nreset = 1'b1;
        test_encode_distinct(1'b0, 32'hC8);
        n_tests++;
        if (bad_addr != 0) begin
            n_fail++;
            $display("FAIL addr_align: %0d misaligned samples, required 0", bad_addr);
        end
    endtask

    initial begin
        nreset = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 1'b0; sel = 1'b0;
        src_addr = '0; src_size = '0; dst_addr = '0;
        for (int i = 0; i < 4096; i++) bm[i] = 8'hEE;
        for (int i = 0; i < 39; i++) bm[i] = pat(i);
        test_reset;
        test_encode_distinct(1'b0, 32'hC8);
        test_encode_runs;
        test_decode;
        test_decode_errors;
        test_boundaries;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
